colour_stats_multi: RTL and testbench

//  Parametrised per-frame colour classifier for the camera path. Classifies every streamed pixel as
//  red/green/blue-dominant and counts all three colours in parallel, not one selected colour.

---
 rtl/colour_stats_multi.sv | 250 +++++++++++++++++++++++++
 tb/tb_colour_stats_multi.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/colour_stats_multi.sv
// colour_stats_multi
//   Per-frame colour classifier for the camera pixel stream. Every pixel is
//   classified as red, green or blue dominant, and all three colours are
//   counted in parallel. The column extent of one selected colour is tracked.
//   All results are published together when the frame ends. A 1-cycle overlay
//   stream shows the classified pixels for the VGA path.
//
//   Handshake: a pixel beat is transferred on every rising clk edge where
//   pix_valid=1. There is no backpressure. sop/eop are only meaningful while
//   pix_valid=1. overlay_valid and stats_valid are single-cycle qualifiers for
//   their data; consumers must take the data in the cycle the qualifier is high.
//
// Ports
//   clk, reset_n                clock, asynchronous active-low reset
//   pix_valid, sop, eop         beat qualifier and frame markers
//   pix_data                    {r,g,b} pixel, CH_W bits per channel
//   upper_thresh                minimum level of the dominant channel
//   colour_sel                  0=red 1=green 2=blue 3=passthrough
//   overlay_data/valid          classified pixel, one cycle after the beat
//   red/green/blue_count        per-colour counts of the last published frame
//   sel_x_min/sel_x_max         column extent of the selected colour
//   sel_detected                selected-colour count >= MIN_PIXELS
//   frame_err                   last frame did not hold exactly IMG_W*IMG_H beats
//   stats_valid                 one-cycle pulse when the result outputs update
//   state_dbg                   current FSM state (0=IDLE, 1=ACTIVE)
module colour_stats_multi #(
    parameter int CH_W       = 4,
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int MIN_PIXELS = 64,
    localparam int CNT_W     = $clog2(IMG_W*IMG_H+1),
    localparam int X_W       = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_valid,
    input  logic              sop,
    input  logic              eop,
    input  logic [3*CH_W-1:0] pix_data,
    input  logic [CH_W-1:0]   upper_thresh,
    input  logic [1:0]        colour_sel,
    output logic [3*CH_W-1:0] overlay_data,
    output logic              overlay_valid,
    output logic [CNT_W-1:0]  red_count,
    output logic [CNT_W-1:0]  green_count,
    output logic [CNT_W-1:0]  blue_count,
    output logic [X_W-1:0]    sel_x_min,
    output logic [X_W-1:0]    sel_x_max,
    output logic              sel_detected,
    output logic              frame_err,
    output logic              stats_valid,
    output logic              state_dbg
);

    localparam logic [CNT_W-1:0] N_PIX   = CNT_W'(IMG_W*IMG_H);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
    localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W-1);
    localparam logic [X_W-1:0]   X_AFTER_FIRST = X_W'((IMG_W > 1) ? 1 : 0);
    localparam logic [CH_W-1:0]  FULL    = {CH_W{1'b1}};
    localparam logic [CH_W-1:0]  ZERO    = '0;

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;
    state_t state_q, state_n;

    // Frame shadows and accumulators
    logic [CH_W-1:0]  thresh_sh;
    logic [1:0]       sel_sh;
    logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b, total;
    logic [X_W-1:0]   x_cnt, xmin, xmax;
    logic             err_acc;

    // FSM decode
    logic start, accept, publish, use_live;

    // Classification
    logic [CH_W-1:0] ch_r, ch_g, ch_b, eff_thresh;
    logic [1:0]      eff_sel;
    logic            is_r, is_g, is_b, sel_match, track;

    // Next accumulator values
    logic [CNT_W-1:0]  cnt_r_n, cnt_g_n, cnt_b_n, total_n;
    logic [X_W-1:0]    x_n, xmin_n, xmax_n;
    logic              err_n, det_n;
    logic [3*CH_W-1:0] ovl_n;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_n;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_n = state_q;
        if (pix_valid && sop)
            state_n = eop ? S_IDLE : S_ACTIVE;   // sop&eop is a complete one-pixel frame
        else if (state_q == S_ACTIVE && pix_valid && eop)
            state_n = S_IDLE;
    end

    // ---------------- FSM: outputs / decode ----------------
    always_comb begin
        start    = pix_valid && sop;
        accept   = (state_q == S_ACTIVE) && pix_valid && !sop;
        publish  = pix_valid && eop && (sop || state_q == S_ACTIVE);
        // The sop beat already belongs to the new frame, so it uses the live
        // settings that are being latched into the shadows on the same edge.
        use_live = (state_q == S_IDLE) || start;
    end

    assign state_dbg = state_q;

    // ---------------- Classification ----------------
    assign ch_r       = pix_data[3*CH_W-1 -: CH_W];
    assign ch_g       = pix_data[2*CH_W-1 -: CH_W];
    assign ch_b       = pix_data[CH_W-1:0];
    assign eff_thresh = use_live ? upper_thresh : thresh_sh;
    assign eff_sel    = use_live ? colour_sel   : sel_sh;

    // Strict '>' against both others: ties are never dominant.
    assign is_r = (ch_r > ch_g) && (ch_r > ch_b) && (ch_r >= eff_thresh);
    assign is_g = (ch_g > ch_r) && (ch_g > ch_b) && (ch_g >= eff_thresh);
    assign is_b = (ch_b > ch_r) && (ch_b > ch_g) && (ch_b >= eff_thresh);

    always_comb begin
        case (eff_sel)
            2'd0:    sel_match = is_r;
            2'd1:    sel_match = is_g;
            2'd2:    sel_match = is_b;
            default: sel_match = 1'b0;
        endcase
    end
    assign track = (eff_sel != 2'd3) && sel_match;

    // ---------------- Accumulator next values ----------------
    always_comb begin
        cnt_r_n = cnt_r;
        cnt_g_n = cnt_g;
        cnt_b_n = cnt_b;
        total_n = total;
        x_n     = x_cnt;
        xmin_n  = xmin;
        xmax_n  = xmax;
        err_n   = err_acc;
        if (start) begin
            // Fresh frame: this beat is pixel 0 at column 0.
            cnt_r_n = CNT_W'(is_r);
            cnt_g_n = CNT_W'(is_g);
            cnt_b_n = CNT_W'(is_b);
            total_n = CNT_W'(1);
            x_n     = X_AFTER_FIRST;
            xmin_n  = track ? '0 : X_LAST;
            xmax_n  = '0;
            err_n   = 1'b0;
        end else if (accept) begin
            if (total < N_PIX) begin
                cnt_r_n = cnt_r + CNT_W'(is_r);
                cnt_g_n = cnt_g + CNT_W'(is_g);
                cnt_b_n = cnt_b + CNT_W'(is_b);
                total_n = total + CNT_W'(1);
                x_n     = (x_cnt == X_LAST) ? '0 : x_cnt + X_W'(1);
                if (track && (x_cnt < xmin)) xmin_n = x_cnt;
                if (track && (x_cnt > xmax)) xmax_n = x_cnt;
            end else begin
                // Overlong frame: the beat is dropped, only the error is kept.
                err_n = 1'b1;
            end
        end
    end

    always_comb begin
        case (eff_sel)
            2'd0:    det_n = (cnt_r_n >= MIN_CNT);
            2'd1:    det_n = (cnt_g_n >= MIN_CNT);
            2'd2:    det_n = (cnt_b_n >= MIN_CNT);
            default: det_n = 1'b0;
        endcase
    end

    always_comb begin
        ovl_n = '0;
        case (eff_sel)
            2'd0:    if (is_r) ovl_n = {FULL, ZERO, ZERO};
            2'd1:    if (is_g) ovl_n = {ZERO, FULL, ZERO};
            2'd2:    if (is_b) ovl_n = {ZERO, ZERO, FULL};
            default: ovl_n = pix_data;
        endcase
    end

    // ---------------- Accumulator registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thresh_sh <= '0;
            sel_sh    <= '0;
            cnt_r     <= '0;
            cnt_g     <= '0;
            cnt_b     <= '0;
            total     <= '0;
            x_cnt     <= '0;
            xmin      <= X_LAST;
            xmax      <= '0;
            err_acc   <= 1'b0;
        end else begin
            if (start) begin
                thresh_sh <= upper_thresh;
                sel_sh    <= colour_sel;
            end
            cnt_r   <= cnt_r_n;
            cnt_g   <= cnt_g_n;
            cnt_b   <= cnt_b_n;
            total   <= total_n;
            x_cnt   <= x_n;
            xmin    <= xmin_n;
            xmax    <= xmax_n;
            err_acc <= err_n;
        end
    end

    // ---------------- Result and overlay registers ----------------
    // Results load from the next-value logic so the eop beat is included and
    // the outputs change in the cycle after the eop beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            red_count     <= '0;
            green_count   <= '0;
            blue_count    <= '0;
            sel_x_min     <= X_LAST;
            sel_x_max     <= '0;
            sel_detected  <= 1'b0;
            frame_err     <= 1'b0;
            stats_valid   <= 1'b0;
            overlay_data  <= '0;
            overlay_valid <= 1'b0;
        end else begin
            stats_valid   <= publish;
            overlay_valid <= pix_valid;
            overlay_data  <= pix_valid ? ovl_n : '0;
            if (publish) begin
                red_count    <= cnt_r_n;
                green_count  <= cnt_g_n;
                blue_count   <= cnt_b_n;
                sel_x_min    <= xmin_n;
                sel_x_max    <= xmax_n;
                sel_detected <= det_n;
                frame_err    <= (total_n != N_PIX) || err_n;
            end
        end
    end

endmodule

// File: tb/tb_colour_stats_multi.sv
module tb_colour_stats_multi;

    localparam int CH_W       = 4;
    localparam int IMG_W      = 16;
    localparam int IMG_H      = 8;
    localparam int MIN_PIXELS = 20;
    localparam int NPIX       = IMG_W*IMG_H;
    localparam int CNT_W      = $clog2(NPIX+1);
    localparam int X_W        = $clog2(IMG_W);

    logic              clk;
    logic              reset_n;
    logic              pix_valid, sop, eop;
    logic [3*CH_W-1:0] pix_data;
    logic [CH_W-1:0]   upper_thresh;
    logic [1:0]        colour_sel;
    logic [3*CH_W-1:0] overlay_data;
    logic              overlay_valid;
    logic [CNT_W-1:0]  red_count, green_count, blue_count;
    logic [X_W-1:0]    sel_x_min, sel_x_max;
    logic              sel_detected, frame_err, stats_valid, state_dbg;

    colour_stats_multi #(
        .CH_W(CH_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .MIN_PIXELS(MIN_PIXELS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .sop(sop), .eop(eop),
        .pix_data(pix_data), .upper_thresh(upper_thresh), .colour_sel(colour_sel),
        .overlay_data(overlay_data), .overlay_valid(overlay_valid),
        .red_count(red_count), .green_count(green_count), .blue_count(blue_count),
        .sel_x_min(sel_x_min), .sel_x_max(sel_x_max), .sel_detected(sel_detected),
        .frame_err(frame_err), .stats_valid(stats_valid), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int r, g, b, xmin, xmax, det, err;
    } stats_t;

    logic [3*CH_W-1:0] exp_q[$];      // expected overlay pixels
    stats_t            stats_q[$];    // expected publishes
    int checks = 0;
    int errors = 0;

    // reference model frame state
    bit               in_frame = 0;
    logic [CH_W-1:0]  sh_th;
    logic [1:0]       sh_sel;
    logic [11:0]      frame_pix[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Dominant channel index (0=r,1=g,2=b) or 3 for none: the channel must be
    // the unique maximum and reach the threshold.
    function automatic int dominant(input logic [11:0] p, input logic [3:0] th);
        int ch[3];
        int mx, n_at_max, idx;
        ch[0] = int'(p[11:8]); ch[1] = int'(p[7:4]); ch[2] = int'(p[3:0]);
        mx = 0; n_at_max = 0; idx = 3;
        for (int i = 0; i < 3; i++) if (ch[i] > mx) mx = ch[i];
        for (int i = 0; i < 3; i++) if (ch[i] == mx) begin n_at_max++; idx = i; end
        if (n_at_max != 1 || mx < int'(th)) return 3;
        return idx;
    endfunction

    function automatic logic [11:0] overlay_model(input logic [11:0] p, input logic [3:0] th,
                                                  input logic [1:0] sel);
        logic [11:0] full;
        if (sel == 2'd3) return p;
        if (dominant(p, th) != int'(sel)) return 12'h000;
        full = 12'hF00;
        return full >> (4*int'(sel));
    endfunction

    task automatic publish_model();
        stats_t s;
        int n, cnt[4];
        n = frame_pix.size();
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0; cnt[3] = 0;
        s.xmin = IMG_W-1; s.xmax = 0;
        for (int i = 0; i < n && i < NPIX; i++) begin
            int d;
            d = dominant(frame_pix[i], sh_th);
            cnt[d]++;
            if (sh_sel != 2'd3 && d == int'(sh_sel)) begin
                if (i % IMG_W < s.xmin) s.xmin = i % IMG_W;
                if (i % IMG_W > s.xmax) s.xmax = i % IMG_W;
            end
        end
        s.r = cnt[0]; s.g = cnt[1]; s.b = cnt[2];
        s.det = (sh_sel != 2'd3 && cnt[sh_sel] >= MIN_PIXELS) ? 1 : 0;
        s.err = (n != NPIX) ? 1 : 0;
        stats_q.push_back(s);
    endtask

    task automatic model_beat(input logic [11:0] p, input logic s, input logic e);
        if (s) begin
            in_frame = 1;
            sh_th    = upper_thresh;
            sh_sel   = colour_sel;
            frame_pix.delete();
        end
        if (in_frame) exp_q.push_back(overlay_model(p, sh_th, sh_sel));
        else          exp_q.push_back(overlay_model(p, upper_thresh, colour_sel));
        if (in_frame) begin
            frame_pix.push_back(p);
            if (e) begin
                publish_model();
                in_frame = 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [11:0] p, input logic s, input logic e);
        model_beat(p, s, e);
        pix_valid = 1'b1; pix_data = p; sop = s; eop = e;
        @(posedge clk); #1;
        pix_valid = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    function automatic logic [11:0] rand_pix();
        logic [3:0] r, g, b;
        r = 4'($urandom_range(0, 15));
        g = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 5))
            0: g = r;                  // tie between r and g
            1: b = g;                  // tie between g and b
            default: ;
        endcase
        return {r, g, b};
    endfunction

    // mode 0: constant pixel, 1: green columns 3..7, 2: random, 3: 880/700/800 cycle
    // wiggle: change live thresh/sel during the frame to exercise the shadows
    task automatic send_frame(input int npix, input int mode, input logic [11:0] cpix,
                              input bit with_eop, input bit gaps, input bit wiggle);
        logic [11:0] p;
        logic [11:0] tri_pat[3];
        tri_pat[0] = 12'h880; tri_pat[1] = 12'h700; tri_pat[2] = 12'h800;
        for (int i = 0; i < npix; i++) begin
            case (mode)
                0:       p = cpix;
                1:       p = ((i % IMG_W) >= 3 && (i % IMG_W) <= 7) ? 12'h0F0 : 12'h000;
                3:       p = tri_pat[i % 3];
                default: p = rand_pix();
            endcase
            if (wiggle && i > 0) begin
                upper_thresh = 4'($urandom_range(0, 15));
                colour_sel   = 2'($urandom_range(0, 3));
            end
            send(p, i == 0, with_eop && (i == npix-1));
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_red"},     32'(red_count),     0);
        check({tag, "_green"},   32'(green_count),   0);
        check({tag, "_blue"},    32'(blue_count),    0);
        check({tag, "_xmin"},    32'(sel_x_min),     IMG_W-1);
        check({tag, "_xmax"},    32'(sel_x_max),     0);
        check({tag, "_det"},     32'(sel_detected),  0);
        check({tag, "_err"},     32'(frame_err),     0);
        check({tag, "_svalid"},  32'(stats_valid),   0);
        check({tag, "_ovalid"},  32'(overlay_valid), 0);
        check({tag, "_state"},   32'(state_dbg),     0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (overlay_valid) begin
                check("overlay_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("overlay_data", 32'(overlay_data), 32'(exp_q.pop_front()));
            end
            if (stats_valid) begin
                check("stats_expected", 32'(stats_q.size() != 0), 1);
                if (stats_q.size() != 0) begin
                    stats_t s;
                    s = stats_q.pop_front();
                    check("red_count",    32'(red_count),    s.r);
                    check("green_count",  32'(green_count),  s.g);
                    check("blue_count",   32'(blue_count),   s.b);
                    check("sel_x_min",    32'(sel_x_min),    s.xmin);
                    check("sel_x_max",    32'(sel_x_max),    s.xmax);
                    check("sel_detected", 32'(sel_detected), s.det);
                    check("frame_err",    32'(frame_err),    s.err);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0; pix_valid = 1'b0; sop = 1'b0; eop = 1'b0;
        pix_data = '0; upper_thresh = 4'd8; colour_sel = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2);

        // Full red frame
        upper_thresh = 4'd8; colour_sel = 2'd0;
        send_frame(NPIX, 0, 12'hF00, 1, 0, 0);
        idle(3);

        // Green columns 3..7 on every line
        colour_sel = 2'd1;
        send_frame(NPIX, 1, 12'h000, 1, 1, 0);
        idle(3);

        // Ties and threshold edge
        upper_thresh = 4'd8; colour_sel = 2'd0;
        send_frame(NPIX, 3, 12'h000, 1, 0, 0);
        idle(3);

        // Short and long frames
        colour_sel = 2'd2; upper_thresh = 4'd4;
        send_frame(100, 2, 12'h000, 1, 0, 0);
        idle(2);
        send_frame(NPIX+5, 2, 12'h000, 1, 0, 0);
        idle(2);

        // Aborted frame then a clean frame; lone eop; single-pixel frame
        colour_sel = 2'd0; upper_thresh = 4'd3;
        send_frame(50, 2, 12'h000, 0, 0, 0);
        colour_sel = 2'd1;
        send_frame(NPIX, 2, 12'h000, 1, 0, 0);
        idle(2);
        send(12'h0F0, 1'b0, 1'b1);
        idle(2);
        colour_sel = 2'd2;
        send(12'h00F, 1'b1, 1'b1);
        idle(2);

        // Passthrough selection
        colour_sel = 2'd3;
        send_frame(NPIX, 2, 12'h000, 1, 1, 0);
        idle(2);

        // Reset mid-frame, then a clean frame
        colour_sel = 2'd0; upper_thresh = 4'd2;
        send_frame(40, 2, 12'h000, 0, 0, 0);
        idle(2);
        in_frame = 0;
        frame_pix.delete();
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2);
        send(12'hF00, 1'b0, 1'b1);      // eop outside a frame after reset
        idle(2);
        send_frame(NPIX, 0, 12'h00F, 1, 0, 0);
        idle(2);

        // Randomised frames, live settings changing inside the frame
        for (int f = 0; f < 8; f++) begin
            upper_thresh = 4'($urandom_range(0, 15));
            colour_sel   = 2'($urandom_range(0, 3));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                send(rand_pix(), 1'b0, 1'($urandom_range(0, 1)));
            case ($urandom_range(0, 3))
                0:       send_frame($urandom_range(1, NPIX-1), 2, 12'h000, 1, 1, 1);
                1:       send_frame(NPIX + $urandom_range(1, 6), 2, 12'h000, 1, 1, 1);
                default: send_frame(NPIX, 2, 12'h000, 1, 1, 1);
            endcase
            idle($urandom_range(1, 4));
        end

        idle(4);
        check("overlay_queue_drained", 32'(exp_q.size()), 0);
        check("stats_queue_drained",   32'(stats_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
